// File: rtl/hyperloglog_param_master.sv
// AXI4-Lite master that turns parameter commands into single-beat register writes
// (1..3 words to one address) or one status read, and returns one status word per command.
module hyperloglog_param_master #(
  parameter int unsigned ADDR_SHIFT     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         user_clk,
  input  logic         user_reset,
  input  logic         s_axis_cmd_valid,
  output logic         s_axis_cmd_ready,
  input  logic [105:0] s_axis_cmd_data,
  output logic [31:0]  m_axil_awaddr,
  output logic         m_axil_awvalid,
  input  logic         m_axil_awready,
  output logic [31:0]  m_axil_wdata,
  output logic [3:0]   m_axil_wstrb,
  output logic         m_axil_wvalid,
  input  logic         m_axil_wready,
  input  logic [1:0]   m_axil_bresp,
  input  logic         m_axil_bvalid,
  output logic         m_axil_bready,
  output logic [31:0]  m_axil_araddr,
  output logic         m_axil_arvalid,
  input  logic         m_axil_arready,
  input  logic [31:0]  m_axil_rdata,
  input  logic [1:0]   m_axil_rresp,
  input  logic         m_axil_rvalid,
  output logic         m_axil_rready,
  output logic         m_axis_rsp_valid,
  input  logic         m_axis_rsp_ready,
  output logic [33:0]  m_axis_rsp_data,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RSP   = 3'd5
  } state_t;

  localparam logic [31:0] LP_TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam logic        LP_TO_EN   = (TIMEOUT_CYCLES != 0);

  function automatic logic [31:0] f_word(input logic [95:0] p, input logic [1:0] i);
    case (i)
      2'd0:    f_word = p[31:0];
      2'd1:    f_word = p[63:32];
      2'd2:    f_word = p[95:64];
      default: f_word = 32'd0;
    endcase
  endfunction

  state_t      r_state;
  logic [95:0] r_payload;
  logic [1:0]  r_op;
  logic [1:0]  r_word_idx;
  logic        r_err;
  logic        r_to;
  logic [31:0] r_wait;
  logic        r_aw_done;
  logic        r_w_done;

  logic        w_cmd_fire;
  logic        w_aw_fire;
  logic        w_w_fire;
  logic        w_aw_done;
  logic        w_w_done;
  logic        w_b_fire;
  logic        w_ar_fire;
  logic        w_r_fire;
  logic        w_progress;
  logic        w_wait_state;
  logic        w_waiting;
  logic        w_to_hit;
  logic        w_err_b;
  logic        w_r_err;
  logic [1:0]  w_next_idx;
  logic [31:0] w_cmd_addr;

  assign w_cmd_fire = s_axis_cmd_valid && s_axis_cmd_ready;
  assign w_aw_fire  = m_axil_awvalid && m_axil_awready;
  assign w_w_fire   = m_axil_wvalid && m_axil_wready;
  assign w_aw_done  = r_aw_done || w_aw_fire;
  assign w_w_done   = r_w_done || w_w_fire;
  assign w_b_fire   = m_axil_bvalid && m_axil_bready;
  assign w_ar_fire  = m_axil_arvalid && m_axil_arready;
  assign w_r_fire   = m_axil_rvalid && m_axil_rready;
  assign w_err_b    = r_err || (m_axil_bresp != 2'b00);
  assign w_r_err    = (m_axil_rresp != 2'b00);
  assign w_next_idx = r_word_idx + 2'd1;
  assign w_cmd_addr = {24'd0, s_axis_cmd_data[103:96]} << ADDR_SHIFT;
  assign w_to_hit   = LP_TO_EN && (r_wait == LP_TO_LAST);
  assign w_waiting  = w_wait_state && !w_progress;

  // Decode which states are waiting on the slave and whether this cycle makes progress
  always_comb begin
    w_progress   = 1'b0;
    w_wait_state = 1'b0;
    case (r_state)
      S_WADDR: begin w_wait_state = 1'b1; w_progress = w_aw_done && w_w_done; end
      S_WRESP: begin w_wait_state = 1'b1; w_progress = w_b_fire;  end
      S_RADDR: begin w_wait_state = 1'b1; w_progress = w_ar_fire; end
      S_RDATA: begin w_wait_state = 1'b1; w_progress = w_r_fire;  end
      default: begin w_wait_state = 1'b0; w_progress = 1'b0;      end
    endcase
  end

  // Command sequencer with registered AXI and stream outputs
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_state          <= S_IDLE;
      r_payload        <= 96'd0;
      r_op             <= 2'd0;
      r_word_idx       <= 2'd0;
      r_err            <= 1'b0;
      r_to             <= 1'b0;
      r_wait           <= 32'd0;
      r_aw_done        <= 1'b0;
      r_w_done         <= 1'b0;
      s_axis_cmd_ready <= 1'b0;
      m_axil_awaddr    <= 32'd0;
      m_axil_awvalid   <= 1'b0;
      m_axil_wdata     <= 32'd0;
      m_axil_wstrb     <= 4'hF;
      m_axil_wvalid    <= 1'b0;
      m_axil_bready    <= 1'b0;
      m_axil_araddr    <= 32'd0;
      m_axil_arvalid   <= 1'b0;
      m_axil_rready    <= 1'b0;
      m_axis_rsp_valid <= 1'b0;
      m_axis_rsp_data  <= 34'd0;
      busy             <= 1'b0;
    end else if (w_waiting && w_to_hit) begin
      // Abort: the slave is considered dead, both ends need a reset afterwards
      m_axil_awvalid   <= 1'b0;
      m_axil_wvalid    <= 1'b0;
      m_axil_bready    <= 1'b0;
      m_axil_arvalid   <= 1'b0;
      m_axil_rready    <= 1'b0;
      r_err            <= 1'b1;
      r_to             <= 1'b1;
      r_wait           <= 32'd0;
      m_axis_rsp_data  <= {2'b11, 32'd0};
      m_axis_rsp_valid <= 1'b1;
      r_state          <= S_RSP;
    end else begin
      if (w_waiting) begin
        r_wait <= r_wait + 32'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            s_axis_cmd_ready <= 1'b0;
            busy             <= 1'b1;
            r_payload        <= s_axis_cmd_data[95:0];
            r_op             <= s_axis_cmd_data[105:104];
            r_word_idx       <= 2'd0;
            r_err            <= 1'b0;
            r_to             <= 1'b0;
            r_wait           <= 32'd0;
            r_aw_done        <= 1'b0;
            r_w_done         <= 1'b0;
            if (s_axis_cmd_data[105:104] == 2'd3) begin
              m_axil_araddr  <= w_cmd_addr;
              m_axil_arvalid <= 1'b1;
              r_state        <= S_RADDR;
            end else begin
              m_axil_awaddr  <= w_cmd_addr;
              m_axil_wdata   <= s_axis_cmd_data[31:0];
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              r_state        <= S_WADDR;
            end
          end else begin
            s_axis_cmd_ready <= 1'b1;
          end
        end
        S_WADDR: begin
          if (w_aw_fire) begin
            m_axil_awvalid <= 1'b0;
          end
          if (w_w_fire) begin
            m_axil_wvalid <= 1'b0;
          end
          r_aw_done <= w_aw_done;
          r_w_done  <= w_w_done;
          if (w_aw_done && w_w_done) begin
            m_axil_bready <= 1'b1;
            r_wait        <= 32'd0;
            r_state       <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (w_b_fire) begin
            m_axil_bready <= 1'b0;
            r_err         <= w_err_b;
            r_wait        <= 32'd0;
            if (r_word_idx == r_op) begin
              m_axis_rsp_data  <= {r_to, w_err_b, 32'd0};
              m_axis_rsp_valid <= 1'b1;
              r_state          <= S_RSP;
            end else begin
              // Same address for every beat; the slave counts words
              r_word_idx     <= w_next_idx;
              m_axil_wdata   <= f_word(r_payload, w_next_idx);
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              r_aw_done      <= 1'b0;
              r_w_done       <= 1'b0;
              r_state        <= S_WADDR;
            end
          end
        end
        S_RADDR: begin
          if (w_ar_fire) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            r_wait         <= 32'd0;
            r_state        <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (w_r_fire) begin
            m_axil_rready    <= 1'b0;
            r_err            <= w_r_err;
            r_wait           <= 32'd0;
            m_axis_rsp_data  <= {1'b0, w_r_err, m_axil_rdata};
            m_axis_rsp_valid <= 1'b1;
            r_state          <= S_RSP;
          end
        end
        S_RSP: begin
          if (m_axis_rsp_ready) begin
            m_axis_rsp_valid <= 1'b0;
            busy             <= 1'b0;
            s_axis_cmd_ready <= 1'b1;
            r_state          <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyperloglog_param_master.sv
// Directed bench for hyperloglog_param_master with a configurable AXI4-Lite slave model.
module tb_hyperloglog_param_master;

  logic         user_clk;
  logic         user_reset;
  logic         s_axis_cmd_valid;
  logic         s_axis_cmd_ready;
  logic [105:0] s_axis_cmd_data;
  logic [31:0]  m_axil_awaddr;
  logic         m_axil_awvalid;
  logic         m_axil_awready;
  logic [31:0]  m_axil_wdata;
  logic [3:0]   m_axil_wstrb;
  logic         m_axil_wvalid;
  logic         m_axil_wready;
  logic [1:0]   m_axil_bresp;
  logic         m_axil_bvalid;
  logic         m_axil_bready;
  logic [31:0]  m_axil_araddr;
  logic         m_axil_arvalid;
  logic         m_axil_arready;
  logic [31:0]  m_axil_rdata;
  logic [1:0]   m_axil_rresp;
  logic         m_axil_rvalid;
  logic         m_axil_rready;
  logic         m_axis_rsp_valid;
  logic         m_axis_rsp_ready;
  logic [33:0]  m_axis_rsp_data;
  logic         busy;

  int n_checks;
  int n_errors;

  // Slave model configuration, written only by the stimulus block
  int          cfg_aw_delay;
  bit          cfg_b_never;
  int          cfg_b_err_idx;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_rresp;

  int          aw_cnt;
  int          cyc_cnt;
  logic        got_aw;
  logic        got_w;
  logic [31:0] q_awaddr[$];
  logic [31:0] q_wdata[$];
  logic [31:0] q_araddr[$];
  int          q_aw_cyc[$];
  int          q_w_cyc[$];

  logic sl_aw_fire, sl_w_fire, sl_aw_now, sl_w_now;

  hyperloglog_param_master #(.ADDR_SHIFT(5), .TIMEOUT_CYCLES(16)) dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .s_axis_cmd_valid(s_axis_cmd_valid), .s_axis_cmd_ready(s_axis_cmd_ready),
    .s_axis_cmd_data(s_axis_cmd_data),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
    .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready),
    .m_axis_rsp_valid(m_axis_rsp_valid), .m_axis_rsp_ready(m_axis_rsp_ready),
    .m_axis_rsp_data(m_axis_rsp_data), .busy(busy)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  assign m_axil_awready = (aw_cnt >= cfg_aw_delay);
  assign m_axil_wready  = 1'b1;
  assign m_axil_arready = 1'b1;
  assign sl_aw_fire = m_axil_awvalid && m_axil_awready;
  assign sl_w_fire  = m_axil_wvalid && m_axil_wready;
  assign sl_aw_now  = got_aw || sl_aw_fire;
  assign sl_w_now   = got_w || sl_w_fire;

  // Slave: logs every beat, answers B once both AW and W landed, answers R one cycle after AR
  always @(posedge user_clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (user_reset) begin
      aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      m_axil_bvalid <= 1'b0; m_axil_bresp <= 2'b00;
      m_axil_rvalid <= 1'b0; m_axil_rdata <= 32'd0; m_axil_rresp <= 2'b00;
    end else begin
      if (sl_aw_fire) aw_cnt <= 0;
      else if (m_axil_awvalid) aw_cnt <= aw_cnt + 1;
      if (sl_aw_fire) begin q_awaddr.push_back(m_axil_awaddr); q_aw_cyc.push_back(cyc_cnt); end
      if (sl_w_fire)  begin q_wdata.push_back(m_axil_wdata);   q_w_cyc.push_back(cyc_cnt);  end
      if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 1'b0;
      if (sl_aw_now && sl_w_now) begin
        got_aw <= 1'b0; got_w <= 1'b0;
        if (!cfg_b_never) begin
          m_axil_bvalid <= 1'b1;
          m_axil_bresp  <= ((q_wdata.size() - 1) == cfg_b_err_idx) ? 2'b10 : 2'b00;
        end
      end else begin
        got_aw <= sl_aw_now; got_w <= sl_w_now;
      end
      if (m_axil_arvalid && m_axil_arready) begin
        q_araddr.push_back(m_axil_araddr);
        m_axil_rvalid <= 1'b1; m_axil_rdata <= cfg_rdata; m_axil_rresp <= cfg_rresp;
      end else if (m_axil_rvalid && m_axil_rready) begin
        m_axil_rvalid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] idx, input logic [95:0] pl);
    int n;
    @(negedge user_clk);
    s_axis_cmd_valid = 1'b1;
    s_axis_cmd_data  = {op, idx, pl};
    n = 0;
    while (!s_axis_cmd_ready && n < 100) begin
      @(negedge user_clk);
      n++;
    end
    chk("cmd_accept", 64'(s_axis_cmd_ready), 64'd1);
    @(posedge user_clk);
    #1;
    s_axis_cmd_valid = 1'b0;
  endtask

  // Cycle 1 is the first negedge after the accepting edge; snap = {aw, w, ar, busy, cmd_ready} there
  task automatic wait_rsp(output int cyc, output logic [33:0] data, output logic [4:0] snap);
    cyc = 0;
    snap = 5'd0;
    do begin
      @(negedge user_clk);
      cyc++;
      if (cyc == 1) snap = {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, busy, s_axis_cmd_ready};
    end while (!m_axis_rsp_valid && cyc < 200);
    chk("rsp_within_bound", 64'(m_axis_rsp_valid), 64'd1);
    data = m_axis_rsp_data;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({s_axis_cmd_ready, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
                            m_axil_arvalid, m_axil_rready, m_axis_rsp_valid, busy}), 64'd0);
    chk({tag, "_addr"}, {m_axil_awaddr, m_axil_araddr}, 64'd0);
    chk({tag, "_wdata"}, 64'(m_axil_wdata), 64'd0);
    chk({tag, "_wstrb"}, 64'(m_axil_wstrb), 64'hF);
    chk({tag, "_rsp"}, 64'(m_axis_rsp_data), 64'd0);
  endtask

  initial begin
    int          cyc;
    int          base_aw, base_w, base_ar, n;
    logic [33:0] rsp;
    logic [4:0]  snap;
    logic [31:0] exp_w[3];
    n_checks = 0; n_errors = 0; cyc_cnt = 0;
    cfg_aw_delay = 0; cfg_b_never = 1'b0; cfg_b_err_idx = -1;
    cfg_rdata = 32'd0; cfg_rresp = 2'b00;
    user_reset = 1'b1; s_axis_cmd_valid = 1'b0; s_axis_cmd_data = 106'd0; m_axis_rsp_ready = 1'b1;

    repeat (3) @(negedge user_clk);
    chk_reset_outputs("reset");
    user_reset = 1'b0;
    @(negedge user_clk);
    chk("cmd_ready_after_reset", 64'(s_axis_cmd_ready), 64'd1);

    // 3-word write, zero-wait slave
    base_aw = q_awaddr.size(); base_w = q_wdata.size();
    send_cmd(2'd2, 8'h05, {32'd3, 32'd2, 32'd1});
    wait_rsp(cyc, rsp, snap);
    chk("w3_first_cycle", 64'(snap), 64'b11010);
    chk("w3_latency", 64'(cyc), 64'd7);
    chk("w3_rsp", 64'(rsp), 64'd0);
    chk("w3_beats", 64'(q_wdata.size() - base_w), 64'd3);
    exp_w[0] = 32'd1; exp_w[1] = 32'd2; exp_w[2] = 32'd3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("w3_addr%0d", i),
          64'((base_aw + i < q_awaddr.size()) ? q_awaddr[base_aw + i] : 32'hxxxxxxxx), 64'hA0);
      chk($sformatf("w3_wdata%0d", i),
          64'((base_w + i < q_wdata.size()) ? q_wdata[base_w + i] : 32'hxxxxxxxx), 64'(exp_w[i]));
    end

    // 2-word write, AW held off 3 cycles so W lands first
    cfg_aw_delay = 3;
    base_aw = q_awaddr.size(); base_w = q_wdata.size();
    send_cmd(2'd1, 8'h07, {32'd0, 32'hDEADBEEF, 32'hCAFEF00D});
    wait_rsp(cyc, rsp, snap);
    chk("w2_rsp", 64'(rsp), 64'd0);
    chk("w2_beats", 64'(q_wdata.size() - base_w), 64'd2);
    chk("w2_w_before_aw", 64'((base_aw < q_aw_cyc.size() && base_w < q_w_cyc.size()) ?
                               (q_w_cyc[base_w] < q_aw_cyc[base_aw]) : 1'bx), 64'd1);
    exp_w[0] = 32'hCAFEF00D; exp_w[1] = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("w2_addr%0d", i),
          64'((base_aw + i < q_awaddr.size()) ? q_awaddr[base_aw + i] : 32'hxxxxxxxx), 64'hE0);
      chk($sformatf("w2_wdata%0d", i),
          64'((base_w + i < q_wdata.size()) ? q_wdata[base_w + i] : 32'hxxxxxxxx), 64'(exp_w[i]));
    end
    cfg_aw_delay = 0;

    // Read OKAY
    base_ar = q_araddr.size();
    cfg_rdata = 32'h00001234; cfg_rresp = 2'b00;
    send_cmd(2'd3, 8'h02, 96'd0);
    wait_rsp(cyc, rsp, snap);
    chk("rd_first_cycle", 64'(snap), 64'b00110);
    chk("rd_latency", 64'(cyc), 64'd3);
    chk("rd_araddr", 64'((base_ar < q_araddr.size()) ? q_araddr[base_ar] : 32'hxxxxxxxx), 64'h40);
    chk("rd_rsp", 64'(rsp), 64'h0_00001234);

    // Read SLVERR
    cfg_rdata = 32'hDEADBEEF; cfg_rresp = 2'b10;
    send_cmd(2'd3, 8'h09, 96'd0);
    wait_rsp(cyc, rsp, snap);
    chk("rd_err_rsp", 64'(rsp), 64'h1_DEADBEEF);

    // 3-word write with SLVERR on beat 1; beat 2 must still go out
    base_w = q_wdata.size();
    cfg_b_err_idx = base_w + 1;
    send_cmd(2'd2, 8'h01, {32'hC, 32'hB, 32'hA});
    wait_rsp(cyc, rsp, snap);
    chk("werr_beats", 64'(q_wdata.size() - base_w), 64'd3);
    chk("werr_beat2", 64'((base_w + 2 < q_wdata.size()) ? q_wdata[base_w + 2] : 32'hxxxxxxxx), 64'hC);
    chk("werr_rsp", 64'(rsp), 64'h1_00000000);
    cfg_b_err_idx = -1;

    // Timeout in WRESP: bready held exactly 16 cycles
    cfg_b_never = 1'b1;
    send_cmd(2'd0, 8'h03, 96'h55);
    n = 0;
    while (!m_axil_bready && n < 50) begin
      @(negedge user_clk);
      n++;
    end
    chk("to_bready_rise", 64'(m_axil_bready), 64'd1);
    repeat (15) @(negedge user_clk);
    chk("to_bready_held", 64'(m_axil_bready), 64'd1);
    @(negedge user_clk);
    chk("to_bready_drop", 64'({m_axil_bready, m_axis_rsp_valid}), 64'b01);
    chk("to_rsp", 64'(m_axis_rsp_data), 64'h3_00000000);
    @(negedge user_clk);
    chk("to_idle", 64'({busy, s_axis_cmd_ready}), 64'b01);

    // Reset asserted mid-WRESP
    send_cmd(2'd0, 8'h03, 96'h66);
    n = 0;
    while (!m_axil_bready && n < 50) begin
      @(negedge user_clk);
      n++;
    end
    chk("rst_in_wresp", 64'(m_axil_bready), 64'd1);
    user_reset = 1'b1;
    @(negedge user_clk);
    chk_reset_outputs("midrst");
    user_reset = 1'b0;
    cfg_b_never = 1'b0;
    @(negedge user_clk);
    chk("midrst_ready", 64'(s_axis_cmd_ready), 64'd1);

    // Recovery read at the top index
    base_ar = q_araddr.size();
    cfg_rdata = 32'hA5A5A5A5; cfg_rresp = 2'b00;
    send_cmd(2'd3, 8'hFF, 96'd0);
    wait_rsp(cyc, rsp, snap);
    chk("rec_araddr", 64'((base_ar < q_araddr.size()) ? q_araddr[base_ar] : 32'hxxxxxxxx), 64'h1FE0);
    chk("rec_rsp", 64'(rsp), 64'h0_A5A5A5A5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
